// File: rtl/ysyx_25030085_pkg.sv
// Shared constants and the writeback entry type used by the ysyx_25030085 writeback unit.
package ysyx_25030085_pkg;

  localparam int NR_REGS    = 32;
  localparam int ADDR_W     = $clog2(NR_REGS);
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/ysyx_25030085_wb_fifo.sv
// In-order buffer of pending ALU writeback entries; DEPTH must be a power of two, >= 2.
module ysyx_25030085_wb_fifo
  import ysyx_25030085_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  wb_entry_t entry_i,
  input  logic      pop_i,
  output wb_entry_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  wb_entry_t        mem_q [DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= entry_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/ysyx_25030085_wbu.sv
// Writeback unit: LSU > buffered ALU > ALU bypass select, registered regfile write, busy scoreboard.
// Optional perf counters are enabled by defining YSYX_25030085_WBU_PERF_EN.
module ysyx_25030085_wbu
  import ysyx_25030085_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               iss_valid,
  input  logic [ADDR_W-1:0]  iss_rd,
  output logic               iss_ready,
  output logic [NR_REGS-1:0] busy,
  input  logic               alu_valid,
  output logic               alu_ready,
  input  logic [ADDR_W-1:0]  alu_rd,
  input  logic [DATA_W-1:0]  alu_data,
  input  logic               lsu_valid,
  input  logic [ADDR_W-1:0]  lsu_rd,
  input  logic [DATA_W-1:0]  lsu_data,
  output logic               rf_wen,
  output logic [ADDR_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata
`ifdef YSYX_25030085_WBU_PERF_EN
  ,
  output logic [31:0]        perf_commits,
  output logic [31:0]        perf_stalls
`endif
);

  logic      fifo_full, fifo_empty, fifo_push, fifo_pop;
  wb_entry_t fifo_head, alu_entry, lsu_entry, sel_entry;
  logic      alu_fire, bypass, sel_valid;

  logic               rf_wen_d, rf_wen_q;
  logic [ADDR_W-1:0]  rf_waddr_q;
  logic [DATA_W-1:0]  rf_wdata_q;
  logic [NR_REGS-1:0] busy_q, busy_d, set_mask, clr_mask;
  logic               iss_fire;

  assign alu_entry = '{rd: alu_rd, data: alu_data};
  assign lsu_entry = '{rd: lsu_rd, data: lsu_data};
  assign alu_ready = !fifo_full;
  assign alu_fire  = alu_valid && alu_ready;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    sel_valid = 1'b0;
    sel_entry = alu_entry;
    fifo_pop  = 1'b0;
    bypass    = 1'b0;
    if (lsu_valid) begin
      sel_valid = 1'b1;
      sel_entry = lsu_entry;
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      sel_entry = fifo_head;
      fifo_pop  = 1'b1;
    end else if (alu_fire) begin
      sel_valid = 1'b1;
      bypass    = 1'b1;
    end
  end

  assign fifo_push = alu_fire && !bypass;
  // x0 entries still drain through the pipe but never reach the regfile.
  assign rf_wen_d  = sel_valid && (sel_entry.rd != '0);

  ysyx_25030085_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .entry_i (alu_entry),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_wen_q <= rf_wen_d;
      if (sel_valid) begin
        rf_waddr_q <= sel_entry.rd;
        rf_wdata_q <= sel_entry.data;
      end
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  // Scoreboard: set at issue, cleared on the edge that registers the write.
  assign iss_ready = !busy_q[iss_rd];
  assign iss_fire  = iss_valid && iss_ready && (iss_rd != '0);

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (iss_fire) set_mask[iss_rd] = 1'b1;
    if (rf_wen_d) clr_mask[sel_entry.rd] = 1'b1;
    busy_d = (busy_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy = busy_q;

  a_no_set_clr_same: assert property (@(posedge clk) disable iff (!rst_n)
    !(iss_fire && rf_wen_d && (iss_rd == sel_entry.rd)));

`ifdef YSYX_25030085_WBU_PERF_EN
  logic [31:0] commits_q, stalls_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commits_q <= '0;
      stalls_q  <= '0;
    end else begin
      if (rf_wen_d)               commits_q <= commits_q + 32'd1;
      if (alu_valid && !alu_ready) stalls_q <= stalls_q + 32'd1;
    end
  end

  assign perf_commits = commits_q;
  assign perf_stalls  = stalls_q;
`endif

endmodule
